// File: rtl/regfile_writeback_arbiter.sv
// Register file write scheduler: ALU writeback, load dirty marking, memory-return FIFO.
// Optional WB_RETURN_CHECK_EN adds shadow dirty tracking and err_unexpected_return.
module regfile_writeback_arbiter #(
  parameter int BITWIDTH  = 16,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int BUF_DEPTH = 4,
  parameter int MAX_WAIT  = 3
) (
  input  logic                         clk,
  input  logic                         sync_rst_n,
  input  logic                         clk_en,
  input  logic                         alu_wr_valid,
  input  logic [ADDR_W-1:0]            alu_wr_addr,
  input  logic [BITWIDTH-1:0]          alu_wr_data,
  output logic                         alu_stall,
  input  logic                         load_issue_valid,
  input  logic [ADDR_W-1:0]            load_issue_addr,
  input  logic                         mem_ret_valid,
  output logic                         mem_ret_ready,
  input  logic [ADDR_W-1:0]            mem_ret_addr,
  input  logic [BITWIDTH-1:0]          mem_ret_data,
  output logic [NUM_REGS-1:0]          rf_write_en,
  output logic [BITWIDTH-1:0]          rf_write_data,
  output logic [NUM_REGS-1:0]          rf_dirty_set,
  output logic [NUM_REGS-1:0]          rf_mem_write_en,
  output logic [BITWIDTH-1:0]          rf_mem_data,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
`ifdef WB_RETURN_CHECK_EN
  ,
  output logic                         err_unexpected_return
`endif
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [ADDR_W-1:0]   addrMem [BUF_DEPTH];
  logic [BITWIDTH-1:0] dataMem [BUF_DEPTH];
  logic [PTR_W-1:0]    rdPtr;
  logic [PTR_W-1:0]    wrPtr;
  logic [CNT_W-1:0]    count;
  logic [WAIT_W-1:0]   waitCnt;
  logic                stallQ;

  logic                full;
  logic                empty;
  logic                enable;
  logic [ADDR_W-1:0]   headAddr;
  logic                aluBlock;
  logic                loadBlock;
  logic                push;
  logic                pop;

  function automatic logic [NUM_REGS-1:0] oneHot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  assign full     = (count == CNT_W'(BUF_DEPTH));
  assign empty    = (count == '0);
  assign enable   = clk_en && sync_rst_n;
  assign headAddr = addrMem[rdPtr];

  // While stalled the ALU no longer competes, so the head is forced through
  assign aluBlock = !empty && alu_wr_valid && !stallQ
                    && (alu_wr_addr == headAddr);
  assign loadBlock = !empty && load_issue_valid
                     && (load_issue_addr == headAddr);

  // ready is taken from the pre-pop occupancy, so a full FIFO refuses a push
  assign push = mem_ret_valid && !full && enable;
  assign pop  = !empty && !aluBlock && !loadBlock && enable;

  assign mem_ret_ready = !full;
  assign buf_count     = count;
  assign alu_stall     = stallQ;
  assign rf_write_data = alu_wr_data;
  assign rf_mem_data   = dataMem[rdPtr];

  always_comb begin
    rf_write_en     = '0;
    rf_dirty_set    = '0;
    rf_mem_write_en = '0;
    if (alu_wr_valid && !stallQ && enable)
      rf_write_en = oneHot(alu_wr_addr);
    if (load_issue_valid && enable)
      rf_dirty_set = oneHot(load_issue_addr);
    if (pop)
      rf_mem_write_en = oneHot(headAddr);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr] <= mem_ret_addr;
      dataMem[wrPtr] <= mem_ret_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      waitCnt <= '0;
      stallQ  <= 1'b0;
    end else if (clk_en) begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
      if (pop || empty)
        waitCnt <= '0;
      else if (aluBlock && waitCnt != WAIT_W'(MAX_WAIT))
        waitCnt <= waitCnt + 1'b1;
      // Stall lands right after the MAX_WAIT-th blocked cycle
      if (pop)
        stallQ <= 1'b0;
      else if (aluBlock && waitCnt >= WAIT_W'(MAX_WAIT - 1))
        stallQ <= 1'b1;
    end
  end

`ifdef WB_RETURN_CHECK_EN
  logic [NUM_REGS-1:0] shadowDirty;
  logic                errQ;
  logic                retExpected;

  assign retExpected = shadowDirty[mem_ret_addr]
                       || (load_issue_valid
                           && load_issue_addr == mem_ret_addr);
  assign err_unexpected_return = errQ;

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      shadowDirty <= '0;
      errQ        <= 1'b0;
    end else if (clk_en) begin
      shadowDirty <= (shadowDirty | rf_dirty_set) & ~rf_mem_write_en;
      if (push && !retExpected)
        errQ <= 1'b1;
    end
  end
`endif

endmodule
